// File: rtl/decode.sv
// Instruction decode stage: register file, MIPS-I subset decoder,
// jump/branch resolution and the ID/EX pipeline registers.
module decode #(
    parameter int WORD_SIZE = 32,
    parameter int REG_ADDR  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] pc_if_id,
    input  logic [WORD_SIZE-1:0] ir_if_id,
    input  logic                 wb_en,
    input  logic [REG_ADDR-1:0]  wb_addr,
    input  logic [WORD_SIZE-1:0] wb_data,
    output logic                 jump,
    output logic [WORD_SIZE-1:0] addr,
    output logic [WORD_SIZE-1:0] pc_id_ex,
    output logic [WORD_SIZE-1:0] rs_data_id_ex,
    output logic [WORD_SIZE-1:0] rt_data_id_ex,
    output logic [WORD_SIZE-1:0] imm_id_ex,
    output logic [REG_ADDR-1:0]  rs_id_ex,
    output logic [REG_ADDR-1:0]  rt_id_ex,
    output logic [REG_ADDR-1:0]  dst_id_ex,
    output logic [2:0]           alu_op_id_ex,
    output logic                 alu_imm_id_ex,
    output logic                 mem_read_id_ex,
    output logic                 mem_write_id_ex,
    output logic                 reg_write_id_ex,
    output logic                 illegal_id_ex
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_NOP = 6'h00;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    logic [WORD_SIZE-1:0] rf [2**REG_ADDR];

    logic [5:0]           op;
    logic [5:0]           funct;
    logic [REG_ADDR-1:0]  rs;
    logic [REG_ADDR-1:0]  rt;
    logic [REG_ADDR-1:0]  rd;
    logic [WORD_SIZE-1:0] rs_val;
    logic [WORD_SIZE-1:0] rt_val;
    logic [WORD_SIZE-1:0] imm_sext;
    logic [WORD_SIZE-1:0] imm_zext;
    logic                 jump_raw;

    logic [WORD_SIZE-1:0] pc_d, pc_q;
    logic [WORD_SIZE-1:0] rs_data_d, rs_data_q;
    logic [WORD_SIZE-1:0] rt_data_d, rt_data_q;
    logic [WORD_SIZE-1:0] imm_d, imm_q;
    logic [REG_ADDR-1:0]  rs_d, rs_q;
    logic [REG_ADDR-1:0]  rt_d, rt_q;
    logic [REG_ADDR-1:0]  dst_d, dst_q;
    logic [2:0]           alu_op_d, alu_op_q;
    logic                 alu_imm_d, alu_imm_q;
    logic                 mem_read_d, mem_read_q;
    logic                 mem_write_d, mem_write_q;
    logic                 reg_write_d, reg_write_q;
    logic                 illegal_d, illegal_q;

    assign op       = ir_if_id[31:26];
    assign rs       = ir_if_id[25:21];
    assign rt       = ir_if_id[20:16];
    assign rd       = ir_if_id[15:11];
    assign funct    = ir_if_id[5:0];
    assign imm_sext = {{(WORD_SIZE-16){ir_if_id[15]}}, ir_if_id[15:0]};
    assign imm_zext = {{(WORD_SIZE-16){1'b0}}, ir_if_id[15:0]};

    // Register file write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wb_en && wb_addr != '0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Operand reads with r0 hardwired and same-cycle writeback bypass.
    always_comb begin
        rs_val = rf[rs];
        rt_val = rf[rt];
        if (wb_en && wb_addr == rs) rs_val = wb_data;
        if (wb_en && wb_addr == rt) rt_val = wb_data;
        if (rs == '0) rs_val = '0;
        if (rt == '0) rt_val = '0;
    end

    // Decode control and resolve jumps/branches.
    always_comb begin
        pc_d        = pc_if_id;
        rs_data_d   = rs_val;
        rt_data_d   = rt_val;
        imm_d       = imm_sext;
        rs_d        = rs;
        rt_d        = rt;
        dst_d       = '0;
        alu_op_d    = ALU_ADD;
        alu_imm_d   = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        illegal_d   = 1'b0;
        jump_raw    = 1'b0;
        addr        = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_NOP: ;
                    F_JR: begin
                        jump_raw = 1'b1;
                        addr     = rs_val;
                    end
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
                        dst_d       = rd;
                        reg_write_d = 1'b1;
                        case (funct)
                            F_SUB:   alu_op_d = ALU_SUB;
                            F_AND:   alu_op_d = ALU_AND;
                            F_OR:    alu_op_d = ALU_OR;
                            F_SLT:   alu_op_d = ALU_SLT;
                            default: alu_op_d = ALU_ADD;
                        endcase
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                alu_imm_d   = 1'b1;
                dst_d       = rt;
                reg_write_d = 1'b1;
                if (op == OP_ANDI) begin
                    imm_d    = imm_zext;
                    alu_op_d = ALU_AND;
                end else if (op == OP_ORI) begin
                    imm_d    = imm_zext;
                    alu_op_d = ALU_OR;
                end
            end
            OP_LW: begin
                alu_imm_d   = 1'b1;
                mem_read_d  = 1'b1;
                dst_d       = rt;
                reg_write_d = 1'b1;
            end
            OP_SW: begin
                alu_imm_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            OP_BEQ: begin
                jump_raw = (rs_val == rt_val);
                addr     = pc_if_id + imm_sext;
            end
            OP_J: begin
                jump_raw = 1'b1;
                addr     = {pc_if_id[WORD_SIZE-1:26], ir_if_id[25:0]};
            end
            default: illegal_d = 1'b1;
        endcase
    end

    assign jump = rst & jump_raw;

    // ID/EX pipeline registers, updated every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            dst_q       <= '0;
            alu_op_q    <= '0;
            alu_imm_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            dst_q       <= dst_d;
            alu_op_q    <= alu_op_d;
            alu_imm_q   <= alu_imm_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
        end
    end

    assign pc_id_ex        = pc_q;
    assign rs_data_id_ex   = rs_data_q;
    assign rt_data_id_ex   = rt_data_q;
    assign imm_id_ex       = imm_q;
    assign rs_id_ex        = rs_q;
    assign rt_id_ex        = rt_q;
    assign dst_id_ex       = dst_q;
    assign alu_op_id_ex    = alu_op_q;
    assign alu_imm_id_ex   = alu_imm_q;
    assign mem_read_id_ex  = mem_read_q;
    assign mem_write_id_ex = mem_write_q;
    assign reg_write_id_ex = reg_write_q;
    assign illegal_id_ex   = illegal_q;

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Instruction decode stage; sits directly downstream of instruction fetch and consumes its `pc_if_id`/`ir_if_id` pipeline registers.
- Holds the 32-entry register file and decodes a MIPS-I integer subset.
- Resolves jumps and branches in this stage and redirects fetch with `jump`/`addr`.
- Registers operands and control into the ID/EX pipeline registers.
- Word-addressed PC: instruction at address P arrives with `pc_if_id` = P+1. One architectural delay slot follows every jump/branch. One load delay slot; no interlocks in this block.

Parameters:
WORD_SIZE, 32, datapath and PC width
REG_ADDR, 5, register-file address width (2**REG_ADDR registers)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
pc_if_id  in  WORD_SIZE  PC+1 of the instruction in ir_if_id
ir_if_id  in  WORD_SIZE  instruction from fetch (0 = NOP)
wb_en  in  1  writeback register write enable
wb_addr  in  REG_ADDR  writeback destination
wb_data  in  WORD_SIZE  writeback value
jump  out  1  combinational redirect to fetch
addr  out  WORD_SIZE  combinational redirect target
pc_id_ex  out  WORD_SIZE  registered pc_if_id
rs_data_id_ex / rt_data_id_ex  out  WORD_SIZE  registered operands
imm_id_ex  out  WORD_SIZE  registered extended immediate
rs_id_ex / rt_id_ex / dst_id_ex  out  REG_ADDR  registered source and destination addresses
alu_op_id_ex  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
alu_imm_id_ex  out  1  ALU B operand = imm
mem_read_id_ex / mem_write_id_ex / reg_write_id_ex  out  1  registered control
illegal_id_ex  out  1  undecodable instruction flag

Behaviour:
- Reset (rst=0, async):
  - All `*_id_ex` outputs clear to 0; `jump`=0 while `rst`=0.
  - Register file is NOT cleared. Its initial contents are 0 in simulation only.
- Register file:
  - Write on rising edge when `wb_en` and `wb_addr`!=0.
  - Reads are combinational. Register 0 always reads 0.
  - Same-cycle bypass: if `wb_en` and `wb_addr`==source!=0, the read returns `wb_data`.
- Decode (op = ir[31:26], rs = ir[25:21], rt = ir[20:16], rd = ir[15:11], funct = ir[5:0]):
  - R-type (op 0): funct 20 ADD, 22 SUB, 24 AND, 25 OR, 2A SLT. Destination rd, `reg_write`=1.
  - R-type funct 08 JR: `jump`=1, `addr` = rs value, `reg_write`=0.
  - R-type funct 00 (incl. all-zero word): NOP, all control 0.
  - Immediate ops: 08 ADDI (sext, ADD), 0C ANDI (zext, AND), 0D ORI (zext, OR). All set `alu_imm`=1 and dest rt.
  - 23 LW: sext, ADD, `mem_read`=1, dest rt, `reg_write`=1.
  - 2B SW: sext, ADD, `mem_write`=1, `reg_write`=0.
  - 04 BEQ: `jump` = (rs value == rt value), `addr` = `pc_if_id` + sext(imm) (mod 2**WORD_SIZE). No EX control.
  - 02 J: `jump`=1, `addr` = {`pc_if_id`[WORD_SIZE-1:26], ir[25:0]}. No EX control.
  - Any other op or funct: NOP control, `illegal_id_ex`=1 for that slot.
- ID/EX registers update every cycle. There is no stall or flush input.
- The delay-slot instruction following a taken jump or branch is decoded and executed normally.
- `rs_data`/`rt_data` are registered regardless of instruction type; EX ignores unused fields.
- Jump in a delay slot: decoded normally, and fetch follows the latest redirect.
- Hazards:
  - BEQ and JR compare or use register-file values plus writeback bypass only.
  - The producer must reach writeback no later than the cycle BEQ/JR is in decode; the toolchain guarantees this.
  - ALU operand hazards are resolved by EX forwarding using `rs_id_ex`/`rt_id_ex`.
- Reset deasserted mid-stream: the first decoded word is whatever fetch presents; fetch presents 0 (NOP) after its own reset.

Test Plan:
1. Assert rst=0 mid-run with nonzero ID/EX state -> all `*_id_ex`=0 immediately (async), `jump`=0; release -> next edge registers the decode of `ir_if_id`.
2. Preload r1=5, r2=7; ir=ADD r3,r1,r2 (0x00221820) -> next edge: `rs_data`=5, `rt_data`=7, `dst`=3, `alu_op`=0, `reg_write`=1, `alu_imm`=0.
3. Same cycle wb_en=1, wb_addr=1, wb_data=0x99 with ADDI r4,r1,-1 (0x2024FFFF) -> `rs_data`=0x99, `imm`=0xFFFFFFFF, `dst`=4; next cycle r1 reads 0x99 without bypass.
4. BEQ r1,r2,-3 at `pc_if_id`=0x10: r1==r2 -> `jump`=1, `addr`=0x0D; r1!=r2 -> `jump`=0. ORI imm 0x8000 -> `imm`=0x00008000.
5. J 0x123 with `pc_if_id`=0xFC000010 -> `addr`=0xFC000123, `jump`=1. JR r5 (r5=0x40) -> `addr`=0x40.
6. wb_en=1, wb_addr=0, wb_data=0xFF then read r0 -> 0. Opcode 0x3F -> `illegal_id_ex`=1, `reg_write`/`mem_*`=0.
